// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - opcode, ALU-op, pc_src and state encodings for the multicycle control unit
// Purpose: shared constants and the FSM state type used by the control unit and its decoder.
// Ports: none (package).
package control_pkg;

  // Opcodes, instr[15:12]
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_ANDI = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_ORI  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_LW   = 4'b1001;
  localparam logic [3:0] OP_SW   = 4'b1010;
  localparam logic [3:0] OP_J    = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // Controle_ALUop codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // pc_src codes
  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_HALT,
    S_FAULT
  } state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - combinational opcode to ALU-control and class decoder
// Purpose: classifies an opcode and gives the ALU operation and operand-B select for it.
// Ports:
//   opcode    in  4  instruction opcode
//   alu_op    out 2  ALU operation code
//   alu_src_b out 1  0=register B, 1=immediate
//   is_alu    out 1  register/immediate ALU instruction
//   is_mem    out 1  LW or SW
//   illegal   out 1  opcode not in the instruction set
module alu_op_decoder
  import control_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [1:0] alu_op,
  output logic       alu_src_b,
  output logic       is_alu,
  output logic       is_mem,
  output logic       illegal
);

  always_comb begin
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    is_alu    = 1'b0;
    is_mem    = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_ADD:  is_alu = 1'b1;
      OP_ADDI: begin is_alu = 1'b1; alu_src_b = 1'b1; end
      OP_SUB:  begin is_alu = 1'b1; alu_op = ALU_SUB; end
      OP_AND:  begin is_alu = 1'b1; alu_op = ALU_AND; end
      OP_ANDI: begin is_alu = 1'b1; alu_op = ALU_AND; alu_src_b = 1'b1; end
      OP_OR:   begin is_alu = 1'b1; alu_op = ALU_OR; end
      OP_ORI:  begin is_alu = 1'b1; alu_op = ALU_OR; alu_src_b = 1'b1; end
      OP_BEQ:  alu_op = ALU_SUB;
      // Address computation is A + imm
      OP_LW, OP_SW: begin is_mem = 1'b1; alu_src_b = 1'b1; end
      OP_J, OP_HALT: ;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit_multiciclo.sv
// rtl/control_unit_multiciclo.sv - multicycle control FSM with memory handshake and wait timeout
// Purpose: sequences fetch/decode/execute for the 8-bit datapath and drives its control strobes.
// Ports:
//   clock, reset            in   clock, synchronous active-high reset
//   instr                   in   instruction word, opcode latched when ir_write=1
//   zero, mem_ready         in   ALU zero flag, memory completion
//   Controle_ALUop, alu_src_b  out  ALU control
//   mem_req, mem_we, instr_fetch  out  memory request interface
//   ir_write, pc_write, pc_src    out  IR / PC control
//   reg_write, mem_to_reg   out  register-file writeback control
//   halted, fault           out  sticky status (absorbing states)
module control_unit_multiciclo
  import control_pkg::*;
#(
  parameter int INSTR_W  = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [1:0]         Controle_ALUop,
  output logic               alu_src_b,
  output logic               mem_req,
  output logic               mem_we,
  output logic               instr_fetch,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               halted,
  output logic               fault
);

  // wait_cnt counts earlier waiting cycles, so the current cycle is the last allowed one here
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [3:0] opcode;
  logic [1:0] dec_alu_op;
  logic       dec_src_b;
  logic       dec_is_alu;
  logic       dec_is_mem;
  logic       dec_illegal;
  logic       req_state;
  logic       timeout;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^instr[INSTR_W-5:0];

  alu_op_decoder u_alu_op_decoder (
    .opcode    (opcode),
    .alu_op    (dec_alu_op),
    .alu_src_b (dec_src_b),
    .is_alu    (dec_is_alu),
    .is_mem    (dec_is_mem),
    .illegal   (dec_illegal)
  );

  assign req_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // mem_ready in the last allowed cycle wins over the timeout
  assign timeout   = req_state && !mem_ready && (wait_cnt >= WAIT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      opcode   <= OP_ADD;
    end else begin
      if (req_state && !mem_ready && !timeout) wait_cnt <= wait_cnt + 8'd1;
      else                                     wait_cnt <= '0;

      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            opcode <= instr[INSTR_W-1 -: 4];
            state  <= S_DECODE;
          end else if (timeout) begin
            state <= S_FAULT;
          end
        end
        S_DECODE: begin
          if (dec_illegal)          state <= S_FAULT;
          else if (dec_is_alu)      state <= S_EXEC;
          else if (dec_is_mem)      state <= S_MEM_ADDR;
          else if (opcode == OP_BEQ) state <= S_BRANCH;
          else if (opcode == OP_J)   state <= S_JUMP;
          else                       state <= S_HALT;
        end
        S_EXEC:     state <= S_ALU_WB;
        S_ALU_WB:   state <= S_FETCH;
        S_MEM_ADDR: state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: begin
          if (mem_ready)    state <= S_MEM_WB;
          else if (timeout) state <= S_FAULT;
        end
        S_MEM_WB:   state <= S_FETCH;
        S_MEM_WR: begin
          if (mem_ready)    state <= S_FETCH;
          else if (timeout) state <= S_FAULT;
        end
        S_BRANCH:   state <= S_FETCH;
        S_JUMP:     state <= S_FETCH;
        S_HALT:     state <= S_HALT;
        S_FAULT:    state <= S_FAULT;
        default:    state <= S_FAULT;
      endcase
    end
  end

  // Reset forces every output low in the same cycle, even mid-request
  always_comb begin
    Controle_ALUop = ALU_ADD;
    alu_src_b      = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    instr_fetch    = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_src         = PC_NEXT;
    reg_write      = 1'b0;
    mem_to_reg     = 1'b0;
    halted         = 1'b0;
    fault          = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req     = 1'b1;
          instr_fetch = 1'b1;
          ir_write    = mem_ready;
          pc_write    = mem_ready;
        end
        S_EXEC: begin
          Controle_ALUop = dec_alu_op;
          alu_src_b      = dec_src_b;
        end
        S_ALU_WB: begin
          Controle_ALUop = dec_alu_op;
          alu_src_b      = dec_src_b;
          reg_write      = 1'b1;
        end
        S_MEM_ADDR: alu_src_b = 1'b1;
        S_MEM_RD:   mem_req = 1'b1;
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        S_BRANCH: begin
          Controle_ALUop = ALU_SUB;
          pc_src         = PC_BRANCH;
          pc_write       = zero;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
        end
        S_HALT:  halted = 1'b1;
        S_FAULT: fault  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_multiciclo.sv
// tb/tb_control_unit_multiciclo.sv - scoreboard bench for the multicycle control unit
module tb_control_unit_multiciclo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [1:0]  Controle_ALUop;
  logic        alu_src_b, mem_req, mem_we, instr_fetch, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        reg_write, mem_to_reg, halted, fault;

  // {aluop[1:0], src_b, req, we, fetch, ir_w, pc_w, pc_src[1:0], reg_w, m2r, halted, fault}
  logic [13:0] outs;
  assign outs = {Controle_ALUop, alu_src_b, mem_req, mem_we, instr_fetch, ir_write,
                 pc_write, pc_src, reg_write, mem_to_reg, halted, fault};

  localparam logic [13:0] OFF     = 14'b0;
  localparam logic [13:0] FW      = {3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000};
  localparam logic [13:0] FG      = {3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 4'b0000};
  localparam logic [13:0] M_ADDR  = {2'b00, 1'b1, 11'b0};
  localparam logic [13:0] M_RD    = {3'b000, 1'b1, 1'b0, 9'b0};
  localparam logic [13:0] M_WR    = {3'b000, 1'b1, 1'b1, 9'b0};
  localparam logic [13:0] M_WB    = {10'b0, 4'b1100};
  localparam logic [13:0] JMP     = {3'b000, 4'b0000, 1'b1, 2'b10, 4'b0000};
  localparam logic [13:0] HALTED  = 14'd2;
  localparam logic [13:0] FAULTED = 14'd1;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        z;
    logic [15:0] ins;
    logic [13:0] exp;
    string       name;
  } stim_t;

  stim_t sb[$];
  stim_t cur;
  int checks = 0;
  int errors = 0;

  control_unit_multiciclo #(.INSTR_W(16), .WAIT_MAX(15)) dut (
    .clock          (clock),
    .reset          (reset),
    .instr          (instr),
    .zero           (zero),
    .mem_ready      (mem_ready),
    .Controle_ALUop (Controle_ALUop),
    .alu_src_b      (alu_src_b),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .instr_fetch    (instr_fetch),
    .ir_write       (ir_write),
    .pc_write       (pc_write),
    .pc_src         (pc_src),
    .reg_write      (reg_write),
    .mem_to_reg     (mem_to_reg),
    .halted         (halted),
    .fault          (fault)
  );

  always #5 clock = ~clock;

  function automatic logic [13:0] alu_e(input logic [1:0] op, input logic sb_i, input logic rw);
    return {op, sb_i, 7'b0, rw, 3'b000};
  endfunction

  function automatic logic [13:0] br_e(input logic z);
    return {2'b01, 1'b0, 4'b0000, z, 2'b01, 4'b0000};
  endfunction

  task automatic push(input logic rst, input logic rdy, input logic z, input logic [15:0] ins,
                      input logic [13:0] e, input string nm);
    stim_t s;
    s.rst = rst; s.rdy = rdy; s.z = z; s.ins = ins; s.exp = e; s.name = nm;
    sb.push_back(s);
  endtask

  // Pops the next entry, drives it just after the edge and lets outputs settle mid-cycle
  task automatic drive_next();
    cur = sb.pop_front();
    reset = cur.rst; mem_ready = cur.rdy; zero = cur.z; instr = cur.ins;
    #4;
  endtask

  task automatic test_reset();
    push(1, 1, 1, 16'h1403, OFF, "reset_hold");
    push(1, 0, 0, 16'h0000, OFF, "reset_hold2");
    push(0, 0, 0, 16'h0000, FW,  "reset_fetch");
    push(0, 0, 0, 16'h0000, FW,  "reset_fetch_wait");
    while (sb.size() != 0) begin
      drive_next();
      checks++;
      if (outs !== cur.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", cur.name, outs, cur.exp);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_alu_ops();
    logic [15:0] ins_t[7] = '{16'h0123, 16'h1403, 16'h2456, 16'h4789, 16'h5abc, 16'h6def, 16'h7012};
    logic [1:0]  op_t[7]  = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic        sb_t[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    push(1, 0, 0, 16'h0000, OFF, "alu_reset");
    for (int i = 0; i < 7; i++) begin
      push(0, 1, 0, ins_t[i], FG, $sformatf("alu%0d_fetch", i));
      push(0, 0, 0, 16'h0000, OFF, $sformatf("alu%0d_decode", i));
      push(0, 0, 0, 16'h0000, alu_e(op_t[i], sb_t[i], 1'b0), $sformatf("alu%0d_exec", i));
      push(0, 0, 0, 16'h0000, alu_e(op_t[i], sb_t[i], 1'b1), $sformatf("alu%0d_wb", i));
    end
    push(0, 0, 0, 16'h0000, FW, "alu_back_to_fetch");
    while (sb.size() != 0) begin
      drive_next();
      checks++;
      if (outs !== cur.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", cur.name, outs, cur.exp);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_branch_jump();
    push(1, 0, 0, 16'h0000, OFF, "br_reset");
    push(0, 1, 0, 16'h8005, FG,  "beq1_fetch");
    push(0, 0, 0, 16'h0000, OFF, "beq1_decode");
    push(0, 0, 1, 16'h0000, br_e(1'b1), "beq_taken");
    push(0, 1, 0, 16'h8005, FG,  "beq2_fetch");
    push(0, 0, 1, 16'h0000, OFF, "beq2_decode");
    push(0, 0, 0, 16'h0000, br_e(1'b0), "beq_not_taken");
    push(0, 1, 0, 16'hB010, FG,  "j_fetch");
    push(0, 0, 0, 16'h0000, OFF, "j_decode");
    push(0, 0, 0, 16'h0000, JMP, "j_jump");
    push(0, 0, 0, 16'h0000, FW,  "j_back_to_fetch");
    while (sb.size() != 0) begin
      drive_next();
      checks++;
      if (outs !== cur.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", cur.name, outs, cur.exp);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_lw_delayed();
    push(1, 0, 0, 16'h0000, OFF,    "lw_reset");
    push(0, 1, 0, 16'h9102, FG,     "lw_fetch");
    push(0, 0, 0, 16'h0000, OFF,    "lw_decode");
    push(0, 0, 0, 16'h0000, M_ADDR, "lw_addr");
    for (int i = 0; i < 3; i++) push(0, 0, 0, 16'h0000, M_RD, $sformatf("lw_rd_wait%0d", i));
    push(0, 1, 0, 16'h0000, M_RD,   "lw_rd_done");
    push(0, 0, 0, 16'h0000, M_WB,   "lw_wb");
    push(0, 0, 0, 16'h0000, FW,     "lw_back_to_fetch");
    while (sb.size() != 0) begin
      drive_next();
      checks++;
      if (outs !== cur.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", cur.name, outs, cur.exp);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_sw_timeout();
    // mem_ready in the 15th waiting cycle is still a success
    push(1, 0, 0, 16'h0000, OFF,    "swok_reset");
    push(0, 1, 0, 16'hA203, FG,     "swok_fetch");
    push(0, 0, 0, 16'h0000, OFF,    "swok_decode");
    push(0, 0, 0, 16'h0000, M_ADDR, "swok_addr");
    for (int i = 0; i < 14; i++) push(0, 0, 0, 16'h0000, M_WR, $sformatf("swok_wait%0d", i));
    push(0, 1, 0, 16'h0000, M_WR,   "swok_last_cycle_ready");
    push(0, 0, 0, 16'h0000, FW,     "swok_back_to_fetch");
    // never ready: fault after 15 waiting cycles
    push(1, 0, 0, 16'h0000, OFF,    "swto_reset");
    push(0, 1, 0, 16'hA203, FG,     "swto_fetch");
    push(0, 0, 0, 16'h0000, OFF,    "swto_decode");
    push(0, 0, 0, 16'h0000, M_ADDR, "swto_addr");
    for (int i = 0; i < 15; i++) push(0, 0, 0, 16'h0000, M_WR, $sformatf("swto_wait%0d", i));
    push(0, 0, 0, 16'h0000, FAULTED, "swto_fault");
    push(0, 1, 0, 16'h0000, FAULTED, "swto_fault_sticky");
    push(0, 0, 0, 16'h0000, FAULTED, "swto_fault_sticky2");
    push(1, 0, 0, 16'h0000, OFF,     "swto_reset_clear");
    push(0, 0, 0, 16'h0000, FW,      "swto_fetch_after_reset");
    while (sb.size() != 0) begin
      drive_next();
      checks++;
      if (outs !== cur.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", cur.name, outs, cur.exp);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_illegal_halt();
    push(1, 0, 0, 16'h0000, OFF,     "ill_reset");
    push(0, 1, 0, 16'hC000, FG,      "ill_fetch");
    push(0, 0, 0, 16'h0000, OFF,     "ill_decode");
    push(0, 0, 0, 16'h0000, FAULTED, "ill_fault");
    push(0, 1, 0, 16'h0000, FAULTED, "ill_fault_sticky");
    push(1, 0, 0, 16'h0000, OFF,     "ill3_reset");
    push(0, 1, 0, 16'h3000, FG,      "ill3_fetch");
    push(0, 0, 0, 16'h0000, OFF,     "ill3_decode");
    push(0, 0, 0, 16'h0000, FAULTED, "ill3_fault");
    push(1, 0, 0, 16'h0000, OFF,     "halt_reset");
    push(0, 1, 0, 16'hF000, FG,      "halt_fetch");
    push(0, 0, 0, 16'h0000, OFF,     "halt_decode");
    for (int i = 0; i < 4; i++) push(0, 1, 0, 16'h0000, HALTED, $sformatf("halt_sticky%0d", i));
    push(1, 0, 0, 16'h0000, OFF,     "halt_reset_clear");
    push(0, 0, 0, 16'h0000, FW,      "halt_fetch_after_reset");
    while (sb.size() != 0) begin
      drive_next();
      checks++;
      if (outs !== cur.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", cur.name, outs, cur.exp);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid_request();
    push(1, 0, 0, 16'h0000, OFF,    "mid_reset");
    push(0, 1, 0, 16'hA000, FG,     "mid_fetch");
    push(0, 1, 0, 16'h0000, OFF,    "mid_decode_ready_ignored");
    push(0, 1, 0, 16'h0000, M_ADDR, "mid_addr");
    push(0, 0, 0, 16'h0000, M_WR,   "mid_wr");
    push(1, 0, 0, 16'h0000, OFF,    "mid_reset_same_cycle");
    push(1, 0, 0, 16'h0000, OFF,    "mid_reset_next_cycle");
    push(0, 0, 0, 16'h0000, FW,     "mid_fetch_after_reset");
    push(0, 1, 0, 16'h1403, FG,     "mid_fetch_go");
    while (sb.size() != 0) begin
      drive_next();
      checks++;
      if (outs !== cur.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", cur.name, outs, cur.exp);
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clock); #1;
    test_reset();
    test_alu_ops();
    test_branch_jump();
    test_lw_delayed();
    test_sw_timeout();
    test_illegal_halt();
    test_reset_mid_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
